// File: rtl/logical_pkg.sv
// -----------------------------------------------------------------------------
// logical_pkg
// Shared types and constants for the logical_arbiter slice.
//   lop_e       : opcode carried to the shared Logical unit (passed through
//                 uninterpreted by the arbiter; all 8 encodings are legal)
//   arb_state_e : arbiter sequencing states
//   LOGICAL_DEFAULT_N : default operand/result width
//   LAT_CNT_W   : width of the latency counter (covers LU_LATENCY up to 15)
//   rr_next()   : next round-robin start index after serving a requester
// -----------------------------------------------------------------------------
package logical_pkg;

    parameter int unsigned LOGICAL_DEFAULT_N = 32;

    localparam int unsigned LAT_CNT_W = 4;

    typedef enum logic [2:0] {
        LOP_AND,
        LOP_OR,
        LOP_XOR,
        LOP_NAND,
        LOP_NOR,
        LOP_XNOR,
        LOP_NOTA,
        LOP_PASSA
    } lop_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } arb_state_e;

    // Index following 'id' in a ring of 'n' requesters.
    function automatic int unsigned rr_next(input int unsigned id, input int unsigned n);
        if (id + 1 >= n) begin
            return 0;
        end
        return id + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. Searches req_valid starting at rr_ptr and
// wrapping modulo NUM_REQ; the first asserted requester wins.
// Ports:
//   req_valid [NUM_REQ]          : request vector
//   rr_ptr    [$clog2(NUM_REQ)]  : index with highest priority this cycle
//   grant     [NUM_REQ]          : one-hot grant (zero when nothing valid)
//   grant_idx [$clog2(NUM_REQ)]  : binary index of the granted requester
//   grant_any                    : some requester was granted
// -----------------------------------------------------------------------------
module rr_arbiter
    import logical_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx,
    output logic                       grant_any
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam logic [IDW:0] NREQ_W = (IDW + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

    logic [NUM_REQ-1:0] rot;
    logic [IDW:0]       sum;
    int unsigned        pos;

    always_comb begin
        // Rotate so that bit 0 is the requester at rr_ptr; the first set bit
        // of the rotated vector is then the round-robin winner.
        rot       = (req_valid >> rr_ptr) | (req_valid << (NUM_REQ - 32'(rr_ptr)));
        grant_any = 1'b0;
        pos       = 0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (!grant_any && rot[j]) begin
                grant_any = 1'b1;
                pos       = j;
            end
        end

        // Undo the rotation: winner index = (rr_ptr + pos) mod NUM_REQ.
        sum = {1'b0, rr_ptr} + (IDW + 1)'(pos);
        if (sum >= NREQ_W) begin
            sum = sum - NREQ_W;
        end
        grant_idx = sum[IDW-1:0];
        grant     = grant_any ? (ONE << grant_idx) : '0;
    end

endmodule

// File: rtl/logical_arbiter.sv
// -----------------------------------------------------------------------------
// logical_arbiter
// Shares one combinational Logical unit between NUM_REQ requesters. A
// round-robin grant accepts one request in IDLE, its operands are held on the
// unit for LU_LATENCY cycles (ISSUE), the result is captured and offered on
// the response port tagged with the requester ID (RESP).
// Ports:
//   clk, rst                 : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready      : per-requester handshake; req_ready one-hot/zero
//   req_a, req_b [NUM_REQ*N] : packed operands, requester i at [i*N +: N]
//   req_op [NUM_REQ*3]       : packed opcodes, requester i at [i*3 +: 3]
//   lu_a, lu_b, lu_op        : registered operands/opcode to the Logical unit
//   lu_c                     : Logical unit result (combinational from lu_*)
//   rsp_valid/rsp_ready      : response handshake
//   rsp_id, rsp_c            : owner of the result and the captured result
//   busy                     : high whenever not in IDLE
// -----------------------------------------------------------------------------
module logical_arbiter
    import logical_pkg::*;
#(
    parameter int unsigned N          = LOGICAL_DEFAULT_N,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned LU_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*N-1:0]         req_a,
    input  logic [NUM_REQ*N-1:0]         req_b,
    input  logic [NUM_REQ*3-1:0]         req_op,
    output logic [N-1:0]                 lu_a,
    output logic [N-1:0]                 lu_b,
    output logic [2:0]                   lu_op,
    input  logic [N-1:0]                 lu_c,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [N-1:0]                 rsp_c,
    output logic                         busy
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam logic [LAT_CNT_W-1:0] LAT_LAST = LAT_CNT_W'(LU_LATENCY - 1);

    arb_state_e             state_q,   state_d;
    logic [IDW-1:0]         rr_ptr_q,  rr_ptr_d;
    logic [LAT_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic [N-1:0]           lu_a_q,    lu_a_d;
    logic [N-1:0]           lu_b_q,    lu_b_d;
    lop_e                   lu_op_q,   lu_op_d;
    logic [N-1:0]           rsp_c_q,   rsp_c_d;
    logic [IDW-1:0]         rsp_id_q,  rsp_id_d;

    logic [NUM_REQ-1:0]     grant;
    logic [IDW-1:0]         grant_idx;
    logic                   grant_any;

    logic [N-1:0]           sel_a;
    logic [N-1:0]           sel_b;
    logic [2:0]             sel_op;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // Payload of the granted requester (one-hot select).
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_a  = req_a[i*N +: N];
                sel_b  = req_b[i*N +: N];
                sel_op = req_op[i*3 +: 3];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lat_cnt_d = lat_cnt_q;
        lu_a_d    = lu_a_q;
        lu_b_d    = lu_b_q;
        lu_op_d   = lu_op_q;
        rsp_c_d   = rsp_c_q;
        rsp_id_d  = rsp_id_q;
        req_ready = '0;
        rsp_valid = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    req_ready = grant;
                    lu_a_d    = sel_a;
                    lu_b_d    = sel_b;
                    lu_op_d   = lop_e'(sel_op);
                    rsp_id_d  = grant_idx;
                    lat_cnt_d = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                lat_cnt_d = lat_cnt_q + LAT_CNT_W'(1);
                if (lat_cnt_q == LAT_LAST) begin
                    rsp_c_d = lu_c;
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    rr_ptr_d = IDW'(rr_next(32'(rsp_id_q), NUM_REQ));
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset aborts everything: no accept and no response in that cycle.
        if (rst) begin
            req_ready = '0;
            rsp_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            lat_cnt_q <= '0;
            lu_a_q    <= '0;
            lu_b_q    <= '0;
            lu_op_q   <= LOP_AND;
            rsp_c_q   <= '0;
            rsp_id_q  <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lat_cnt_q <= lat_cnt_d;
            lu_a_q    <= lu_a_d;
            lu_b_q    <= lu_b_d;
            lu_op_q   <= lu_op_d;
            rsp_c_q   <= rsp_c_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

    assign lu_a   = lu_a_q;
    assign lu_b   = lu_b_q;
    assign lu_op  = lu_op_q;
    assign rsp_c  = rsp_c_q;
    assign rsp_id = rsp_id_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: doc/logical_arbiter.md
Name: logical_arbiter

Overview:
- Shares one Logical unit (bitwise a/b -> c datapath) between NUM_REQ requesters.
- Each requester presents operands and an opcode over a valid/ready handshake.
- Round-robin grant; the block sequences the shared unit through issue, wait and capture, then returns the result tagged with the requester ID.
- Sits between client blocks and the single Logical instance.

Parameters:
N, 32, operand/result width
NUM_REQ, 4, number of requesters (2..8)
LU_LATENCY, 1, cycles operands are held on the Logical unit before result capture (1..15)

Ports:
clk  input  1  clock, all logic rising-edge
rst  input  1  synchronous reset, active-high
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
req_a  input  NUM_REQ*N  packed operand A, requester i at [i*N +: N]
req_b  input  NUM_REQ*N  packed operand B
req_op  input  NUM_REQ*3  packed opcode (logical_pkg::lop_e)
lu_a  output  N  operand A to Logical unit
lu_b  output  N  operand B to Logical unit
lu_op  output  3  opcode to Logical unit
lu_c  input  N  Logical unit result (combinational from lu_*)
rsp_valid  output  1  response valid
rsp_ready  input  1  response accept
rsp_id  output  $clog2(NUM_REQ)  ID of the requester that owns rsp_c
rsp_c  output  N  captured result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0, lat_cnt=0. Outputs lu_a, lu_b, lu_op, rsp_c, rsp_id = 0; rsp_valid=0; req_ready=0; busy=0.
- Reset in any state aborts an in-flight op. No response is produced and no req_ready pulse occurs in the reset cycle.
- FSM states:
  - IDLE:
    - If any req_valid, grant g = first set index searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
    - req_ready[g]=1 combinationally in this cycle only.
    - On that edge, latch req_a[g], req_b[g], req_op[g] into lu_* registers and g into rsp_id; clear lat_cnt; go to ISSUE.
    - If no req_valid, stay in IDLE with req_ready=0.
  - ISSUE:
    - lu_* held stable; lat_cnt increments each cycle.
    - When lat_cnt==LU_LATENCY-1, capture lu_c into rsp_c and go to RESP.
    - With LU_LATENCY=1 this is exactly one cycle.
  - RESP:
    - rsp_valid=1; rsp_c and rsp_id held stable until accepted.
    - On rsp_valid&rsp_ready: go to IDLE; rr_ptr = (rsp_id+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- req_ready is 0 in ISSUE and RESP. Only one request is in flight.
- Requesters must hold valid and payload until their ready. A deasserted req_valid in IDLE is never granted. Dropping valid before ready is legal; that request is simply not accepted.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers wait; the round-robin order guarantees each asserted requester is served within NUM_REQ grants.
- Latency from accept edge to rsp_valid high: LU_LATENCY+1 cycles. Minimum issue interval: LU_LATENCY+2 cycles.
- Backpressure: rsp_ready low holds RESP indefinitely. No new grant occurs while holding.
- Opcode is passed through uninterpreted. All 8 encodings are legal.
- lu_* keep their last values in IDLE; they are not cleared after a response.

Decomposition:
- logical_pkg holds:
  - typedef enum logic [2:0] lop_e {LOP_AND, LOP_OR, LOP_XOR, LOP_NAND, LOP_NOR, LOP_XNOR, LOP_NOTA, LOP_PASSA}
  - typedef enum logic [1:0] arb_state_e {IDLE, ISSUE, RESP}
  - parameter LOGICAL_DEFAULT_N = 32
- One sub-module, rr_arbiter: a combinational round-robin pick of req_valid from rr_ptr, producing a one-hot grant and a binary index.
- The FSM, latency counter and registers stay in logical_arbiter.

Test Plan:
- Single request, default params: requester 2 with a=0xF0F0_F0F0, b=0xFF00_FF00, op=LOP_AND -> req_ready[2] for one cycle; rsp_valid 2 cycles after accept; rsp_id=2; rsp_c=0xF000_F000.
- All four requesters valid continuously, rr_ptr=0: grants occur in order 0,1,2,3,0; each response carries the matching ID and the correct XOR of its operands.
- Backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid, rsp_c and rsp_id stable; req_ready stays 0 throughout; accepted on the cycle rsp_ready rises.
- LU_LATENCY=3, op=LOP_NOR, a=0, b=0x0000_FFFF -> rsp_c=0xFFFF_0000; rsp_valid 4 cycles after accept; lu_* stable for all 3 ISSUE cycles.
- Reset in ISSUE: rst high one cycle -> next cycle state=IDLE, rsp_valid=0, rr_ptr=0; the aborted op never responds. A subsequent request from requester 0 is granted first.
- Wrap-around: after serving requester 3, only requesters 3 and 1 valid -> requester 1 is granted next (rr_ptr wrapped to 0, then searches up to 1).
